// File: rtl/sae_best_vector_select_if.sv
// Candidate and result channels of the best-vector selector.
// The master drives candidates and accepts results; the slave is the selector.
interface sae_best_vector_select_if #(
  parameter int MV_W  = 6,
  parameter int SAE_W = 32,
  parameter int CNT_W = 10
);
  // Candidate channel
  logic                    cand_valid;
  logic                    cand_ready;
  logic signed [MV_W-1:0]  cand_mvx;
  logic signed [MV_W-1:0]  cand_mvy;
  logic        [SAE_W-1:0] cand_sae;
  logic                    cand_last;

  // Result channel
  logic                    best_valid;
  logic                    best_ready;
  logic signed [MV_W-1:0]  best_mvx;
  logic signed [MV_W-1:0]  best_mvy;
  logic        [SAE_W-1:0] best_sae;
  logic        [CNT_W-1:0] best_count;

  modport master (
    output cand_valid, cand_mvx, cand_mvy, cand_sae, cand_last, best_ready,
    input  cand_ready, best_valid, best_mvx, best_mvy, best_sae, best_count
  );

  modport slave (
    input  cand_valid, cand_mvx, cand_mvy, cand_sae, cand_last, best_ready,
    output cand_ready, best_valid, best_mvx, best_mvy, best_sae, best_count
  );
endinterface

// File: rtl/sae_best_vector_select.sv
// Minimum-SAE motion-vector selector.
// Accepts one SAE result per candidate vector, keeps the earliest strict
// minimum over a full search window and presents it on a valid/ready output.
module sae_best_vector_select #(
  parameter int N     = 46,
  parameter int M     = 16,
  parameter int SAE_W = 32,
  parameter int MV_W  = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  sae_best_vector_select_if.slave       bus,
  output logic                          proto_err,
  output logic                          busy
);

  localparam int R        = (N - M) / 2;
  localparam int NUM_CAND = (2 * R + 1) * (2 * R + 1);
  localparam int CNT_W    = $clog2(NUM_CAND + 1);

  localparam logic signed [MV_W-1:0] R_POS    = MV_W'(R);
  localparam logic signed [MV_W-1:0] R_NEG    = MV_W'(-R);
  localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(NUM_CAND);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic signed [MV_W-1:0]  best_mvx_q, best_mvx_d;
  logic signed [MV_W-1:0]  best_mvy_q, best_mvy_d;
  logic        [SAE_W-1:0] best_sae_q, best_sae_d;
  logic        [CNT_W-1:0] count_q, count_d;
  logic                    proto_err_q, proto_err_d;

  // A vector component is usable only inside the +/-R search window.
  function automatic logic comp_in_range(input logic signed [MV_W-1:0] v);
    return (v >= R_NEG) && (v <= R_POS);
  endfunction

  logic             xfer;
  logic             cand_ok;
  logic [CNT_W-1:0] count_inc;
  logic [CNT_W-1:0] count_after;
  logic             reach_full;

  assign xfer        = (state_q == COLLECT) && bus.cand_valid;
  assign cand_ok     = comp_in_range(bus.cand_mvx) && comp_in_range(bus.cand_mvy);
  assign count_inc   = count_q + 1'b1;
  assign count_after = cand_ok ? count_inc : count_q;
  assign reach_full  = cand_ok && (count_inc == CNT_FULL);

  // Next-state and datapath update for the search FSM.
  always_comb begin
    state_d     = state_q;
    best_mvx_d  = best_mvx_q;
    best_mvy_d  = best_mvy_q;
    best_sae_d  = best_sae_q;
    count_d     = count_q;
    proto_err_d = proto_err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          count_d     = '0;
          proto_err_d = 1'b0;
          best_sae_d  = '1;
          best_mvx_d  = '0;
          best_mvy_d  = '0;
          state_d     = COLLECT;
        end
      end

      COLLECT: begin
        if (xfer) begin
          if (!cand_ok) begin
            // Out-of-window vectors are dropped but flagged.
            proto_err_d = 1'b1;
          end else begin
            count_d = count_inc;
            // Strict less-than keeps the earliest candidate on ties.
            if (bus.cand_sae < best_sae_q) begin
              best_sae_d = bus.cand_sae;
              best_mvx_d = bus.cand_mvx;
              best_mvy_d = bus.cand_mvy;
            end
          end

          if (bus.cand_last || reach_full) begin
            state_d = DONE;
            // Early/late termination means the producer miscounted.
            if (bus.cand_last && (count_after != CNT_FULL)) proto_err_d = 1'b1;
            if (reach_full && !bus.cand_last)                proto_err_d = 1'b1;
          end
        end
      end

      DONE: begin
        if (bus.best_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any search in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      best_mvx_q  <= '0;
      best_mvy_q  <= '0;
      best_sae_q  <= '1;
      count_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      best_mvx_q  <= best_mvx_d;
      best_mvy_q  <= best_mvy_d;
      best_sae_q  <= best_sae_d;
      count_q     <= count_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Handshake outputs decode the registered state only, so nothing on the
  // candidate inputs reaches the result outputs combinationally.
  assign bus.cand_ready = (state_q == COLLECT);
  assign bus.best_valid = (state_q == DONE);
  assign busy           = (state_q != IDLE);

  assign bus.best_mvx   = best_mvx_q;
  assign bus.best_mvy   = best_mvy_q;
  assign bus.best_sae   = best_sae_q;
  assign bus.best_count = count_q;
  assign proto_err      = proto_err_q;

endmodule

// File: tb/tb_sae_best_vector_select.sv
// Directed bench for sae_best_vector_select with a result scoreboard.
module tb_sae_best_vector_select;

  localparam int MV_W  = 6;
  localparam int SAE_W = 32;
  localparam int CNT_W = 10;

  typedef struct packed {
    logic [MV_W-1:0]  mvx;
    logic [MV_W-1:0]  mvy;
    logic [SAE_W-1:0] sae;
    logic [CNT_W-1:0] cnt;
    logic             perr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic proto_err;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];

  sae_best_vector_select_if #(.MV_W(MV_W), .SAE_W(SAE_W), .CNT_W(CNT_W)) bus ();

  sae_best_vector_select dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bus       (bus),
    .proto_err (proto_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_count_clr", 64'(bus.best_count), 64'd0);
    check("start_sae_ones", 64'(bus.best_sae), 64'hFFFF_FFFF);
    check("start_perr_clr", 64'(proto_err), 64'd0);
  endtask

  task automatic send_cand(input int x, input int y, input logic [SAE_W-1:0] sae, input logic last);
    logic got;
    got = 1'b0;
    bus.cand_valid = 1'b1;
    bus.cand_mvx   = MV_W'(x);
    bus.cand_mvy   = MV_W'(y);
    bus.cand_sae   = sae;
    bus.cand_last  = last;
    for (int k = 0; k < 50; k++) begin
      got = bus.cand_ready;
      tick();
      if (got) break;
    end
    if (!got) check("cand_accept_timeout", 64'd0, 64'd1);
    bus.cand_valid = 1'b0;
    bus.cand_last  = 1'b0;
  endtask

  // Sweeps the window in x-major order; the 961st candidate carries last.
  task automatic sweep(input int minx, input int miny, input logic [SAE_W-1:0] minsae,
                       input bit bubbles, input int limit);
    int idx;
    logic [SAE_W-1:0] s;
    idx = 0;
    for (int x = -15; x <= 15; x++) begin
      for (int y = -15; y <= 15; y++) begin
        if (idx >= limit) return;
        if (x == minx && y == miny) s = minsae;
        else if (bubbles)           s = SAE_W'($urandom_range(1, 5000));
        else                        s = 32'd1000;
        if (bubbles) repeat ($urandom_range(0, 2)) tick();
        send_cand(x, y, s, idx == 960);
        idx++;
      end
    end
  endtask

  task automatic collect(input string tag, input logic start_on_hs);
    exp_t e;
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.best_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_valid"}, 64'(seen), 64'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      e = '0;
    end else begin
      e = sb.pop_front();
    end
    check({tag, "_mvx"},   64'($unsigned(bus.best_mvx)), 64'(e.mvx));
    check({tag, "_mvy"},   64'($unsigned(bus.best_mvy)), 64'(e.mvy));
    check({tag, "_sae"},   64'(bus.best_sae),   64'(e.sae));
    check({tag, "_count"}, 64'(bus.best_count), 64'(e.cnt));
    check({tag, "_perr"},  64'(proto_err),      64'(e.perr));
    bus.best_ready = 1'b1;
    start = start_on_hs;
    tick();
    bus.best_ready = 1'b0;
    start = 1'b0;
    check({tag, "_valid_fall"}, 64'(bus.best_valid), 64'd0);
    check({tag, "_idle"},       64'(busy),           64'd0);
    check({tag, "_held_sae"},   64'(bus.best_sae),   64'(e.sae));
    tick();
    check({tag, "_still_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    exp_t e;
    bus.cand_valid = 1'b0;
    bus.cand_mvx   = '0;
    bus.cand_mvy   = '0;
    bus.cand_sae   = '0;
    bus.cand_last  = 1'b0;
    bus.best_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_cand_ready", 64'(bus.cand_ready), 64'd0);
    check("rst_best_valid", 64'(bus.best_valid), 64'd0);
    check("rst_busy",       64'(busy),           64'd0);
    check("rst_perr",       64'(proto_err),      64'd0);
    check("rst_count",      64'(bus.best_count), 64'd0);
    check("rst_mvx",        64'($unsigned(bus.best_mvx)), 64'd0);
    check("rst_mvy",        64'($unsigned(bus.best_mvy)), 64'd0);
    check("rst_sae",        64'(bus.best_sae),   64'hFFFF_FFFF);
    rst_n = 1'b1;
    tick();

    // Full sweep with a unique minimum at (3,-2)
    do_start();
    e = '{mvx: MV_W'(3), mvy: MV_W'(-2), sae: 32'd17, cnt: 10'd961, perr: 1'b0};
    sb.push_back(e);
    sweep(3, -2, 32'd17, 1'b0, 961);
    check("full_latency", 64'(bus.best_valid), 64'd1);
    collect("full", 1'b0);

    // Ties keep the earliest; early last flags an error
    do_start();
    e = '{mvx: MV_W'(0), mvy: MV_W'(0), sae: 32'd50, cnt: 10'd3, perr: 1'b1};
    sb.push_back(e);
    send_cand(0, 0, 32'd50, 1'b0);
    send_cand(1, 1, 32'd50, 1'b0);
    send_cand(-4, 2, 32'd50, 1'b1);
    collect("tie", 1'b0);

    // Out-of-range vector is discarded even with SAE 0
    do_start();
    e = '{mvx: MV_W'(2), mvy: MV_W'(2), sae: 32'd9, cnt: 10'd1, perr: 1'b1};
    sb.push_back(e);
    send_cand(16, 0, 32'd0, 1'b0);
    check("oor_perr_sticky", 64'(proto_err), 64'd1);
    check("oor_count", 64'(bus.best_count), 64'd0);
    send_cand(2, 2, 32'd9, 1'b1);
    collect("oor", 1'b0);

    // Backpressure in DONE with start and cand_valid pulsing
    do_start();
    e = '{mvx: MV_W'(1), mvy: MV_W'(2), sae: 32'd5, cnt: 10'd1, perr: 1'b1};
    sb.push_back(e);
    send_cand(1, 2, 32'd5, 1'b1);
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      bus.cand_valid = ~i[0];
      bus.cand_mvx   = MV_W'(-1);
      bus.cand_sae   = 32'd0;
      tick();
      check("bp_cand_ready", 64'(bus.cand_ready), 64'd0);
      check("bp_best_valid", 64'(bus.best_valid), 64'd1);
      check("bp_sae_stable", 64'(bus.best_sae),   64'd5);
      check("bp_count_stable", 64'(bus.best_count), 64'd1);
    end
    start = 1'b0;
    bus.cand_valid = 1'b0;
    collect("bp", 1'b1);

    // Random bubbles, minimum at the final candidate
    do_start();
    e = '{mvx: MV_W'(15), mvy: MV_W'(15), sae: 32'd0, cnt: 10'd961, perr: 1'b0};
    sb.push_back(e);
    sweep(15, 15, 32'd0, 1'b1, 961);
    collect("bubble", 1'b0);

    // Reset mid-search abandons the search
    do_start();
    sweep(-7, 9, 32'd3, 1'b0, 100);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",       64'(busy),           64'd0);
    check("mid_rst_best_valid", 64'(bus.best_valid), 64'd0);
    check("mid_rst_cand_ready", 64'(bus.cand_ready), 64'd0);
    check("mid_rst_count",      64'(bus.best_count), 64'd0);
    check("mid_rst_sae",        64'(bus.best_sae),   64'hFFFF_FFFF);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_no_result", 64'(bus.best_valid), 64'd0);
    do_start();
    e = '{mvx: MV_W'(-7), mvy: MV_W'(9), sae: 32'd3, cnt: 10'd961, perr: 1'b0};
    sb.push_back(e);
    sweep(-7, 9, 32'd3, 1'b0, 961);
    collect("rerun", 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
